// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and note codes for the note sequencer.
// Loop playback is enabled by defining NOTE_SEQ_LOOP_EN.
package note_seq_pkg;

  localparam int NOTE_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NOTE,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [3:0] NOTE_DO  = 4'h0;
  localparam logic [3:0] NOTE_RE  = 4'h1;
  localparam logic [3:0] NOTE_MI  = 4'h2;
  localparam logic [3:0] NOTE_FA  = 4'h3;
  localparam logic [3:0] NOTE_SOL = 4'h4;
  localparam logic [3:0] NOTE_LA  = 4'h5;
  localparam logic [3:0] NOTE_SI  = 4'h6;

endpackage

// File: rtl/duration_timer.sv
// duration_timer: loadable down-counter, expire pulses while enabled at zero.
// Shared by the hold and gap phases of the note sequencer.
module duration_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Not gated by load: the FSM uses expire to decide to reload.
  assign expire = en && (cnt_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: buffers note codes and plays them to the 7-seg decoder.
// Define NOTE_SEQ_LOOP_EN to loop playback until stop instead of ending.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NOTE_W-1:0]          note_in,
  input  logic                       note_valid,
  output logic                       note_accept,
  input  logic                       clear,
  input  logic                       play,
  input  logic                       stop,
  output logic [NOTE_W-1:0]          note_out,
  output logic                       note_ready,
  output logic                       sounding,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       index_q, index_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic                ready_q, ready_d;
  logic [NOTE_W-1:0]   mem_q [DEPTH];

  logic                wr_en;
  logic                tmr_load;
  logic [TW-1:0]       tmr_ld_val;
  logic                tmr_en;
  logic                tmr_exp;
  logic                step;
  logic                last_note;
  logic [IW-1:0]       nxt_idx;

  duration_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .en       (tmr_en),
    .expire   (tmr_exp)
  );

  assign last_note = (CW'(index_q) == count_q - CW'(1));
  assign nxt_idx   = last_note ? '0 : index_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    note_out_d  = note_out_q;
    ready_d     = 1'b0;
    wr_en       = 1'b0;
    tmr_load    = 1'b0;
    tmr_ld_val  = HOLD_LD;
    tmr_en      = 1'b0;
    note_accept = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        note_accept = note_valid && !clear && !reset
                      && (count_q < CW'(DEPTH));
        if (clear) begin
          count_d = '0;
        end else if (note_accept) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
        if (play && !stop && !clear && count_q != '0) begin
          state_d    = S_NOTE;
          index_d    = '0;
          note_out_d = mem_q[0];
          ready_d    = 1'b1;
          tmr_load   = 1'b1;
          tmr_ld_val = HOLD_LD;
        end
      end
      S_NOTE: begin
        tmr_en = 1'b1;
        if (tmr_exp) begin
          if (GAP_CYCLES > 0) begin
            state_d    = S_GAP;
            tmr_load   = 1'b1;
            tmr_ld_val = GAP_LD;
          end else begin
            step = 1'b1;
          end
        end
      end
      S_GAP: begin
        tmr_en = 1'b1;
        step   = tmr_exp;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step) begin
`ifdef NOTE_SEQ_LOOP_EN
      state_d    = S_NOTE;
      index_d    = nxt_idx;
      note_out_d = mem_q[nxt_idx];
      ready_d    = 1'b1;
      tmr_load   = 1'b1;
      tmr_ld_val = HOLD_LD;
`else
      if (last_note) begin
        state_d    = S_DONE;
        note_out_d = '0;
      end else begin
        state_d    = S_NOTE;
        index_d    = nxt_idx;
        note_out_d = mem_q[nxt_idx];
        ready_d    = 1'b1;
        tmr_load   = 1'b1;
        tmr_ld_val = HOLD_LD;
      end
`endif
    end

    // Abort keeps the buffer so the same melody can be replayed.
    if (stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      note_out_d = '0;
      ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      index_q    <= '0;
      note_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      note_out_q <= note_out_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[count_q[IW-1:0]] <= note_in;
    end
  end

  assign note_out   = note_out_q;
  assign note_ready = ready_q;
  assign sounding   = (state_q == S_NOTE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign count      = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer.
// Loop-mode checks run when NOTE_SEQ_LOOP_EN is defined.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int HOLD  = 8;
  localparam int GAP   = 2;
  localparam int PER   = HOLD + GAP;

  typedef struct {
    int         cyc;
    logic [3:0] code;
    bit         is_done;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] note_in;
  logic       note_valid;
  logic       note_accept;
  logic       clear;
  logic       play;
  logic       stop;
  logic [3:0] note_out;
  logic       note_ready;
  logic       sounding;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  ev_t        exp_q[$];
  ev_t        ev;
  logic [3:0] mm [DEPTH];
  int         mc = 0;
  int         t;
  int         at;

  note_sequencer #(
    .DEPTH       (DEPTH),
    .NOTE_W      (4),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .note_in     (note_in),
    .note_valid  (note_valid),
    .note_accept (note_accept),
    .clear       (clear),
    .play        (play),
    .stop        (stop),
    .note_out    (note_out),
    .note_ready  (note_ready),
    .sounding    (sounding),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && (note_ready || done)) begin
      if (exp_q.size() == 0) begin
        check("unexp_evt", {30'd0, note_ready, done}, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check(ev.is_done ? "done_cyc" : "rdy_cyc", cyc, ev.cyc);
        check("evt_kind", done, ev.is_done);
        if (!ev.is_done) begin
          check("note_code", note_out, ev.code);
          check("snd_on", sounding, 1);
        end else begin
          check("done_out", note_out, 0);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [3:0] c);
    bit ea;
    ea = (mc < DEPTH);
    note_in    = c;
    note_valid = 1'b1;
    #1 check("accept", note_accept, ea);
    if (ea) begin
      mm[mc] = c;
      mc++;
    end
    @(negedge clock);
    note_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    mc = 0;
    check("count_clr", count, 0);
  endtask

  task automatic start_play(output int ts, input int n_ev, input bit wdone);
    ts = cyc;
    for (int k = 0; k < n_ev; k++)
      exp_q.push_back('{ts + 1 + k * PER, mm[k % mc], 1'b0});
    if (wdone)
      exp_q.push_back('{ts + 1 + mc * PER, 4'h0, 1'b1});
    play = 1'b1;
    @(negedge clock);
    play = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int at_c);
    at_c = -1;
    for (int i = 0; i < maxc; i++) begin
      if (!busy) begin
        at_c = cyc;
        break;
      end
      @(negedge clock);
    end
    if (at_c < 0) check("idle_timeout", busy, 0);
  endtask

  task automatic play_run();
    int ts, ai;
    start_play(ts, mc, 1'b1);
    wait_idle(mc * PER + 20, ai);
    check("busy_end", ai, ts + 2 + mc * PER);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    note_in = '0;
    note_valid = 1'b1;
    clear = 1'b0;
    play = 1'b0;
    stop = 1'b0;
    step(3);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_out", note_out, 0);
    check("rst_flags", {note_ready, sounding, done, note_accept}, 0);
    note_valid = 1'b0;
    reset = 1'b0;
    step(1);

    wr(NOTE_FA);
    wr(NOTE_LA);
    wr(4'h9);
    check("count3", count, 3);

`ifndef NOTE_SEQ_LOOP_EN
    play_run();

    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) wr(4'(i % 7));
    check("count_full", count, DEPTH);
    note_in = NOTE_SI;
    note_valid = 1'b1;
    clear = 1'b1;
    #1 check("acc_clr", note_accept, 0);
    @(negedge clock);
    note_valid = 1'b0;
    clear = 1'b0;
    mc = 0;
    check("clr_win", count, 0);

    wr(NOTE_SI);
    wr(NOTE_RE);
    wr(NOTE_MI);
    wr(NOTE_SOL);
    start_play(t, 2, 1'b0);
    while (cyc < t + 13) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_out", note_out, 0);
    check("stop_snd", sounding, 0);
    check("stop_cnt", count, 4);
    step(20);
    check("stop_sb", exp_q.size(), 0);
    play_run();

    play = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    play = 1'b0;
    stop = 1'b0;
    check("ps_busy", busy, 0);

    do_clear();
    play = 1'b1;
    @(negedge clock);
    play = 1'b0;
    check("empty_busy", busy, 0);
    step(5);
    check("empty_busy2", busy, 0);

    wr(NOTE_DO);
    wr(NOTE_SOL);
    start_play(t, 2, 1'b1);
    step(3);
    note_in = NOTE_SI;
    note_valid = 1'b1;
    #1 check("acc_busy", note_accept, 0);
    step(2);
    note_valid = 1'b0;
    check("cnt_busy", count, 2);
    wait_idle(3 * PER, at);
    check("busy_end2", at, t + 2 + 2 * PER);
    check("sb_empty2", exp_q.size(), 0);

    start_play(t, 2, 1'b0);
    while (cyc < t + 19) @(negedge clock);
    check("gap_snd", sounding, 0);
    check("gap_hold", note_out, mm[1]);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mc = 0;
    check("mrst_cnt", count, 0);
    check("mrst_busy", busy, 0);
    check("mrst_out", note_out, 0);
    check("mrst_flags", {note_ready, sounding, done}, 0);
    check("mrst_sb", exp_q.size(), 0);
`else
    do_clear();
    wr(NOTE_MI);
    wr(NOTE_LA);
    start_play(t, 10, 1'b0);
    while (cyc < t + 100) @(negedge clock);
    check("loop_sb", exp_q.size(), 0);
    check("loop_busy", busy, 1);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("loop_stop", busy, 0);
    check("loop_out", note_out, 0);
    check("loop_cnt", count, 2);
`endif

    step(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Melody controller in front of the Notas 7-segment note decoder.
- Accepts up to DEPTH 4-bit note codes into an internal buffer.
- On play, presents each code to the decoder's a,b,c,d inputs and issues one ready strobe per note.
- Holds each note for a fixed duration, then a silent gap, then advances; reports completion.

Parameters:
- DEPTH, 16, number of note slots in the buffer.
- NOTE_W, 4, note code width (maps to decoder a,b,c,d).
- HOLD_CYCLES, 8, cycles each note sounds (must be >=1).
- GAP_CYCLES, 2, silent cycles after each note (0 means no gap).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- note_in  in  NOTE_W  code to append to the buffer.
- note_valid  in  1  append request.
- note_accept  out  1  high when an append is taken this cycle.
- clear  in  1  empty the buffer (IDLE only).
- play  in  1  start playback (IDLE only).
- stop  in  1  abort playback.
- note_out  out  NOTE_W  to decoder: note_out[3]=a, [2]=b, [1]=c, [0]=d.
- note_ready  out  1  to decoder ready; one-cycle pulse at each note start.
- sounding  out  1  high during the hold phase.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when playback completes.
- count  out  $clog2(DEPTH+1)  notes currently stored.

Behaviour:
- Clock is one; reset is synchronous and active-high, named reset.
- On reset:
  - state IDLE; count, index, timers = 0.
  - note_out=0; note_ready, sounding, busy, done, note_accept = 0.
  - Buffer contents are don't-care.
- States: IDLE, NOTE, GAP, DONE.
- IDLE:
  - note_accept = note_valid && count<DEPTH && !clear.
  - On accept: mem[count]<=note_in; count++.
  - Full (count==DEPTH): further writes are dropped with no error.
  - clear: count<=0 next cycle. clear beats a same-cycle write.
  - play with count>0 and !stop: index<=0, go to NOTE.
  - play with count==0 is ignored. play and stop in the same cycle: stop wins, nothing happens.
- NOTE entry cycle: note_out<=mem[index], note_ready=1 for that cycle only, sounding=1.
  - NOTE lasts exactly HOLD_CYCLES cycles, including the entry cycle.
  - Then go to GAP, or skip GAP when GAP_CYCLES==0.
- GAP: sounding=0; note_out holds the last code; lasts GAP_CYCLES cycles.
- End of GAP (or end of NOTE when there is no gap):
  - index==count-1: go to DONE.
  - Otherwise index++ and go to NOTE.
- DONE: single cycle. done=1, busy=1, sounding=0, note_out=0. Then IDLE.
- Timing from play sampled at edge t:
  - k-th note_ready (k from 0) at cycle t+1+k*(HOLD_CYCLES+GAP_CYCLES).
  - done at t+1+count*(HOLD_CYCLES+GAP_CYCLES).
- busy is 1 in NOTE, GAP and DONE.
- While busy:
  - note_accept=0.
  - clear and play are ignored.
  - stop goes to IDLE next cycle: note_out=0, sounding=0, no done pulse, buffer and count retained.
- A reset mid-playback behaves as a full reset: count returns to 0.

Optional Feature:
- Macro NOTE_SEQ_LOOP_EN.
- Defined: after the last note's gap, index wraps to 0 and playback re-enters NOTE with a new note_ready. DONE is never entered and done never pulses; only stop or reset ends playback.
- Undefined: single pass ending in DONE, as described above.

Decomposition:
- Package note_seq_pkg holds:
  - state enum (S_IDLE, S_NOTE, S_GAP, S_DONE);
  - NOTE_W default;
  - note code constants used by the bench (e.g. NOTE_DO=4'h0 .. NOTE_SI=4'h6).
- One sub-module, duration_timer: loadable down-counter with load value, enable and a one-cycle expire output. Used for both the hold and gap phases.

Test Plan:
- Reset, then write codes 3,5,9 -> count=3, note_accept high for each write. play at t -> note_ready at t+1, t+11, t+21 with note_out 3,5,9; done at t+31; busy low at t+32.
- Write 16 codes, then a 17th with note_valid=1 -> note_accept=0, count stays 16. clear and a write in the same cycle -> count=0.
- play at t with 4 notes, stop at t+13 -> IDLE at t+14, note_out=0, no done pulse, count=4. Replay restarts from code 0.
- play with count=0 -> busy stays 0, no note_ready. Raise note_valid during playback -> note_accept=0, count unchanged.
- Assert reset during GAP of note 2 -> next cycle all outputs 0, count=0.
- With NOTE_SEQ_LOOP_EN and 2 notes -> note_ready every 10 cycles, codes alternating, no done over 100 cycles. stop ends playback.
